bullet_item_gen_seq: RTL
========================

// Module: bullet_item_gen_seq
// PURPOSE
//   Sequential, parametrised generator for the magazine bitmap and both players' item slots.
//   Owns a free-running LFSR, builds a round on an i_start request, and holds the results
//   until the next round; the game Top no longer stores generated values.
//   Adds three things: a configurable magazine depth, per-slot keep masks (refill only
//   selected slots), and a guarantee that every round has at least one live and one blank.
// PARAMETERS
//   MAG_MAX     8        max bullets; bitmap width; must be >= 2
//   ITEM_SLOTS  6        item slots per player
//   ITEM_W      3        bits per item code
//   ITEM_TYPES  7        legal codes 0..ITEM_TYPES-1; must be <= 2**ITEM_W
//   HP_W        3        hp input width
//   SEED        16'hACE1 LFSR reset value; 0 is replaced by 16'hACE1
// PORTS
//   i_clk            in   1                   clock
//   i_rst            in   1                   synchronous active-high reset
//   i_start          in   1                   round request; sampled only in IDLE
//   i_entropy        in   4                   mixed into LFSR on accepted start (game timer)
//   i_bullet_num     in   $clog2(MAG_MAX)+1   requested bullets N
//   i_hp_p0          in   HP_W                player 0 hp
//   i_hp_p1          in   HP_W                player 1 hp
//   i_item_keep_p0   in   ITEM_SLOTS          1 = slot k of p0 keeps its old value
//   i_item_keep_p1   in   ITEM_SLOTS          1 = slot k of p1 keeps its old value
//   o_bullet_bitmap  out  MAG_MAX             bit k = 1 live, 0 blank; bits >= N are 0
//   o_live_cnt       out  $clog2(MAG_MAX)+1   popcount of o_bullet_bitmap
//   o_items_p0       out  ITEM_SLOTS*ITEM_W   slot k at [k*ITEM_W +: ITEM_W]
//   o_items_p1       out  ITEM_SLOTS*ITEM_W   same layout as o_items_p0
//   o_busy           out  1                   high in every state except IDLE
//   o_done           out  1                   one-cycle pulse; outputs are updated in the same cycle
// BEHAVIOUR
//   Reset: state IDLE; lfsr = SEED; all outputs and shadow registers 0. Reset wins over
//     everything, including mid-round; a partial round is discarded and outputs go to 0.
//   LFSR: 16-bit Galois, shifts right every cycle in every state.
//     Update: if lfsr[0], lfsr = (lfsr>>1) ^ 16'hB400, else lfsr = lfsr>>1.
//     On an accepted start: lfsr = step(lfsr) ^ {12'b0,i_entropy}.
//     If that result is 0, load SEED instead.
//   Clamp at start (latched into N): i_bullet_num < 2 gives 2; i_bullet_num > MAG_MAX gives MAG_MAX.
//   FSM: IDLE -> GEN_B -> FIX -> GEN_I -> DONE -> IDLE.
//     IDLE: i_start=1 latches N, the hp values and the keep masks; clears the shadow bitmap.
//     GEN_B: N cycles; cycle k writes shadow_bitmap[k] = lfsr[0].
//     FIX: 1 cycle. If all N bits are 0, set bit0. If all N bits are 1, clear bit N-1.
//     GEN_I: 2*ITEM_SLOTS cycles. p0 slots 0..S-1 are written first, then p1 slots 0..S-1.
//       raw = lfsr[ITEM_W-1:0] + opponent hp[ITEM_W-1:0], truncated to ITEM_W bits.
//       The opponent of p0 is p1, and the opponent of p1 is p0.
//       code = (raw >= ITEM_TYPES) ? ITEM_TYPES-1 : raw.
//       If the slot's keep bit is 1, the old output value is copied into the shadow.
//     DONE: 1 cycle; o_done=1. The shadow registers load o_bullet_bitmap, o_live_cnt and
//       o_items_* on the edge that enters DONE.
//   Latency: o_done is high N+2*ITEM_SLOTS+1 clocks after the edge that samples i_start
//     (21 for N=8, S=6). i_start may be issued again from the cycle after o_done.
//   i_start outside IDLE is ignored and has no queueing.
//   Hp and keep inputs are used only as latched at start; later changes have no effect.
//   Outputs are stable between o_done pulses; no partial round is ever visible.
// TESTING
//   1. Reset: i_rst held 2 cycles -> o_bullet_bitmap=0, o_items_*=0, o_busy=0, o_done=0.
//   2. N=8, S=6, keep=0, start one cycle -> o_done exactly 21 clocks later; 1 <= o_live_cnt <= 7;
//      every item code <= 6; o_live_cnt equals popcount of the bitmap.
//   3. i_bullet_num=4 -> bitmap[7:4]=0 and o_live_cnt in 1..3.
//      i_bullet_num=0 -> bitmap[7:2]=0 and o_live_cnt=1.
//      i_bullet_num=12 -> treated as 8, with the same latency as scenario 2.
//   4. Keep: round A, then round B with keep_p0=6'b111111 and keep_p1=6'b000001 ->
//      o_items_p0 equals round A bit-for-bit, and p1 slot 0 equals round A's p1 slot 0.
//   5. i_start pulsed while o_busy=1 -> exactly one o_done, and the latency is measured from
//      the first start. The bench also forces the LFSR to all-zero or all-one sequences and
//      checks that FIX produces bit0=1 or bit N-1=0 respectively.
//   6. i_rst asserted in GEN_I -> next cycle IDLE, outputs 0, no o_done; a fresh start then
//      completes normally.

Source files
------------

// File: rtl/bullet_item_gen_seq_if.sv
// Round request / result bundle between the game top and the bullet/item generator.
interface bullet_item_gen_seq_if #(
  parameter int MAG_MAX    = 8,
  parameter int ITEM_SLOTS = 6,
  parameter int ITEM_W     = 3,
  parameter int HP_W       = 3
);
  localparam int NW = $clog2(MAG_MAX) + 1;
  localparam int IW = ITEM_SLOTS * ITEM_W;

  logic                  i_start;
  logic [3:0]            i_entropy;
  logic [NW-1:0]         i_bullet_num;
  logic [HP_W-1:0]       i_hp_p0;
  logic [HP_W-1:0]       i_hp_p1;
  logic [ITEM_SLOTS-1:0] i_item_keep_p0;
  logic [ITEM_SLOTS-1:0] i_item_keep_p1;
  logic [MAG_MAX-1:0]    o_bullet_bitmap;
  logic [NW-1:0]         o_live_cnt;
  logic [IW-1:0]         o_items_p0;
  logic [IW-1:0]         o_items_p1;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output i_start, i_entropy, i_bullet_num,
    output i_hp_p0, i_hp_p1,
    output i_item_keep_p0, i_item_keep_p1,
    input  o_bullet_bitmap, o_live_cnt,
    input  o_items_p0, o_items_p1,
    input  o_busy, o_done
  );

  modport slave (
    input  i_start, i_entropy, i_bullet_num,
    input  i_hp_p0, i_hp_p1,
    input  i_item_keep_p0, i_item_keep_p1,
    output o_bullet_bitmap, o_live_cnt,
    output o_items_p0, o_items_p1,
    output o_busy, o_done
  );
endinterface

// File: rtl/bullet_item_gen_seq.sv
// Sequential magazine/item generator: builds one round per start, holds results until next.
module bullet_item_gen_seq #(
  parameter int          MAG_MAX    = 8,
  parameter int          ITEM_SLOTS = 6,
  parameter int          ITEM_W     = 3,
  parameter int          ITEM_TYPES = 7,
  parameter int          HP_W       = 3,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input logic                  i_clk,
  input logic                  i_rst,
  bullet_item_gen_seq_if.slave if_bus
);
  localparam int NW = $clog2(MAG_MAX) + 1;
  localparam int CW = NW + $clog2(2 * ITEM_SLOTS + 1);
  localparam int IW = ITEM_SLOTS * ITEM_W;

  localparam logic [15:0] LP_SEED = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [ITEM_W:0] LP_TYPES = (ITEM_W + 1)'(ITEM_TYPES);
  localparam logic [ITEM_W-1:0] LP_MAXC = ITEM_W'(ITEM_TYPES - 1);
  localparam logic [CW-1:0] LP_ONE = CW'(1);
  localparam logic [CW-1:0] LP_ILAST = CW'(2 * ITEM_SLOTS - 1);
  localparam logic [MAG_MAX-1:0] LP_BIT0 = MAG_MAX'(1);
  localparam logic [MAG_MAX-1:0] LP_ONES = '1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GEN_B = 3'd1;
  localparam logic [2:0] S_FIX   = 3'd2;
  localparam logic [2:0] S_GEN_I = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            r_state;
  logic [15:0]           r_lfsr;
  logic [NW-1:0]         r_n;
  logic [CW-1:0]         r_cnt;
  logic [ITEM_W-1:0]     r_hp0;
  logic [ITEM_W-1:0]     r_hp1;
  logic [ITEM_SLOTS-1:0] r_keep0;
  logic [ITEM_SLOTS-1:0] r_keep1;
  logic [MAG_MAX-1:0]    r_sbm;
  logic [IW-1:0]         r_sit0;
  logic [IW-1:0]         r_sit1;
  logic [MAG_MAX-1:0]    r_bm;
  logic [NW-1:0]         r_live;
  logic [IW-1:0]         r_it0;
  logic [IW-1:0]         r_it1;

  logic [15:0]        w_step;
  logic [15:0]        w_mix;
  logic [15:0]        w_seeded;
  logic [NW-1:0]      w_nclamp;
  logic [CW-1:0]      w_nlast;
  logic [MAG_MAX-1:0] w_mask;
  logic [MAG_MAX-1:0] w_top;
  logic [MAG_MAX-1:0] w_onehot;
  logic [MAG_MAX-1:0] w_masked;
  logic [NW-1:0]      w_pop;
  logic [ITEM_W-1:0]  w_raw0;
  logic [ITEM_W-1:0]  w_raw1;
  logic [ITEM_W-1:0]  w_code0;
  logic [ITEM_W-1:0]  w_code1;
  logic [IW-1:0]      w_sit0_nx;
  logic [IW-1:0]      w_sit1_nx;

  always_comb begin
    w_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
    w_mix = w_step ^ {12'b0, if_bus.i_entropy};
    w_seeded = (w_mix == 16'h0) ? LP_SEED : w_mix;
    if (if_bus.i_bullet_num < NW'(2))
      w_nclamp = NW'(2);
    else if (if_bus.i_bullet_num > NW'(MAG_MAX))
      w_nclamp = NW'(MAG_MAX);
    else
      w_nclamp = if_bus.i_bullet_num;
    w_nlast = {{(CW-NW){1'b0}}, r_n} - LP_ONE;
    // mask of the N live positions; shifting by MAG_MAX yields all ones
    w_mask = ~(LP_ONES << r_n);
    w_top = w_mask ^ (w_mask >> 1);
    w_onehot = LP_BIT0 << r_cnt;
    w_masked = r_sbm & w_mask;
    w_pop = '0;
    for (int i = 0; i < MAG_MAX; i++)
      w_pop = w_pop + NW'(r_sbm[i]);
    w_raw0 = r_lfsr[ITEM_W-1:0] + r_hp1;
    w_raw1 = r_lfsr[ITEM_W-1:0] + r_hp0;
    w_code0 = ({1'b0, w_raw0} >= LP_TYPES) ? LP_MAXC : w_raw0;
    w_code1 = ({1'b0, w_raw1} >= LP_TYPES) ? LP_MAXC : w_raw1;
  end

  always_comb begin
    w_sit0_nx = r_sit0;
    w_sit1_nx = r_sit1;
    for (int k = 0; k < ITEM_SLOTS; k++) begin
      if (r_cnt == CW'(k))
        w_sit0_nx[k*ITEM_W +: ITEM_W] =
          r_keep0[k] ? r_it0[k*ITEM_W +: ITEM_W] : w_code0;
      if (r_cnt == CW'(k + ITEM_SLOTS))
        w_sit1_nx[k*ITEM_W +: ITEM_W] =
          r_keep1[k] ? r_it1[k*ITEM_W +: ITEM_W] : w_code1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= LP_SEED;
      r_n     <= '0;
      r_cnt   <= '0;
      r_hp0   <= '0;
      r_hp1   <= '0;
      r_keep0 <= '0;
      r_keep1 <= '0;
      r_sbm   <= '0;
      r_sit0  <= '0;
      r_sit1  <= '0;
      r_bm    <= '0;
      r_live  <= '0;
      r_it0   <= '0;
      r_it1   <= '0;
    end else begin
      r_lfsr <= w_step;
      case (r_state)
        S_IDLE: begin
          if (if_bus.i_start) begin
            r_lfsr  <= w_seeded;
            r_n     <= w_nclamp;
            r_hp0   <= if_bus.i_hp_p0[ITEM_W-1:0];
            r_hp1   <= if_bus.i_hp_p1[ITEM_W-1:0];
            r_keep0 <= if_bus.i_item_keep_p0;
            r_keep1 <= if_bus.i_item_keep_p1;
            r_sbm   <= '0;
            r_cnt   <= '0;
            r_state <= S_GEN_B;
          end
        end
        S_GEN_B: begin
          if (r_lfsr[0])
            r_sbm <= r_sbm | w_onehot;
          if (r_cnt == w_nlast) begin
            r_cnt   <= '0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        S_FIX: begin
          // every round must hold at least one live and one blank
          if (w_masked == '0)
            r_sbm <= r_sbm | LP_BIT0;
          else if (w_masked == w_mask)
            r_sbm <= r_sbm & ~w_top;
          r_state <= S_GEN_I;
        end
        S_GEN_I: begin
          r_sit0 <= w_sit0_nx;
          r_sit1 <= w_sit1_nx;
          if (r_cnt == LP_ILAST) begin
            r_bm    <= r_sbm;
            r_live  <= w_pop;
            r_it0   <= w_sit0_nx;
            r_it1   <= w_sit1_nx;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_bus.o_bullet_bitmap = r_bm;
  assign if_bus.o_live_cnt      = r_live;
  assign if_bus.o_items_p0      = r_it0;
  assign if_bus.o_items_p1      = r_it1;
  assign if_bus.o_busy          = (r_state != S_IDLE);
  assign if_bus.o_done          = (r_state == S_DONE);
endmodule
